// File: rtl/fpmul_bf16_pipe.sv
// fpmul_bf16_pipe: 3-stage bfloat16 multiplier, valid/ready handshake, flush-to-zero.
// Optional macro FPMUL_ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
`default_nettype none

module fpmul_bf16_pipe #(
    parameter int BIT_WIDTH = 16,
    parameter int EXP_BIAS  = 127
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] a_operand,
    input  logic [BIT_WIDTH-1:0] b_operand,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BIT_WIDTH-1:0] result,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int EXP_W  = 8;
    localparam int MAN_W  = BIT_WIDTH - 1 - EXP_W;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam logic [EXP_W-1:0]     EXP_MAX = {EXP_W{1'b1}};
    localparam logic [BIT_WIDTH-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // One global enable: the whole pipe freezes while the output is blocked.
    logic advance;
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    // ---------------- Stage 1: unpack, sign, exponent sum, mantissa product
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [PROD_W-1:0] prod;
    logic signed [9:0] exp_sum;

    assign a_sign = a_operand[BIT_WIDTH-1];
    assign b_sign = b_operand[BIT_WIDTH-1];
    assign a_exp  = a_operand[BIT_WIDTH-2 -: EXP_W];
    assign b_exp  = b_operand[BIT_WIDTH-2 -: EXP_W];
    assign a_man  = a_operand[MAN_W-1:0];
    assign b_man  = b_operand[MAN_W-1:0];

    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == EXP_MAX) && (a_man == '0);
    assign b_inf  = (b_exp == EXP_MAX) && (b_man == '0);
    assign a_nan  = (a_exp == EXP_MAX) && (a_man != '0);
    assign b_nan  = (b_exp == EXP_MAX) && (b_man != '0);

    assign prod    = {1'b1, a_man} * {1'b1, b_man};
    assign exp_sum = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - $signed(10'(EXP_BIAS));

    logic              s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
    logic signed [9:0] s1_exp;
    logic [PROD_W-1:0] s1_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_nan   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_zero  <= 1'b0;
            s1_exp   <= '0;
            s1_prod  <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_sign  <= a_sign ^ b_sign;
            s1_nan   <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
            s1_inf   <= a_inf || b_inf;
            s1_zero  <= a_zero || b_zero;
            s1_exp   <= exp_sum;
            s1_prod  <= prod;
        end
    end

    // ---------------- Stage 2: normalize, round, exponent adjust
    logic              norm;
    logic [MAN_W-1:0]  man_n, man_final;
    logic signed [9:0] exp_n, exp_final;

    assign norm  = s1_prod[PROD_W-1];
    assign man_n = norm ? s1_prod[PROD_W-2 -: MAN_W] : s1_prod[PROD_W-3 -: MAN_W];
    assign exp_n = s1_exp + 10'(norm);

`ifdef FPMUL_ROUND_NEAREST_EN
    logic             guard, sticky, round_up;
    logic [SIG_W-1:0] man_r;

    assign guard    = norm ? s1_prod[MAN_W]       : s1_prod[MAN_W-1];
    assign sticky   = norm ? |s1_prod[MAN_W-1:0]  : |s1_prod[MAN_W-2:0];
    assign round_up = guard && (sticky || man_n[0]);
    assign man_r    = {1'b0, man_n} + SIG_W'(round_up);
    // A carry out of the mantissa leaves it all-zero and bumps the exponent.
    assign man_final = man_r[MAN_W-1:0];
    assign exp_final = exp_n + 10'(man_r[MAN_W]);
`else
    logic unused_prod_lsbs;
    assign unused_prod_lsbs = ^s1_prod[MAN_W-1:0];
    assign man_final = man_n;
    assign exp_final = exp_n;
`endif

    logic              s2_valid, s2_sign, s2_nan, s2_inf, s2_zero;
    logic signed [9:0] s2_exp;
    logic [MAN_W-1:0]  s2_man;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_nan   <= 1'b0;
            s2_inf   <= 1'b0;
            s2_zero  <= 1'b0;
            s2_exp   <= '0;
            s2_man   <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_nan   <= s1_nan;
            s2_inf   <= s1_inf;
            s2_zero  <= s1_zero;
            s2_exp   <= exp_final;
            s2_man   <= man_final;
        end
    end

    // ---------------- Stage 3: special-case select, range check, pack
    logic [BIT_WIDTH-1:0] pack_res;
    logic                 pack_ovf, pack_unf;

    always_comb begin
        pack_res = {s2_sign, s2_exp[EXP_W-1:0], s2_man};
        pack_ovf = 1'b0;
        pack_unf = 1'b0;
        if (s2_nan) begin
            pack_res = QNAN;
        end else if (s2_inf) begin
            pack_res = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
        end else if (s2_zero) begin
            pack_res = {s2_sign, {(BIT_WIDTH-1){1'b0}}};
        end else if (s2_exp >= 10'sd255) begin
            pack_res = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
            pack_ovf = 1'b1;
        end else if (s2_exp <= 10'sd0) begin
            pack_res = {s2_sign, {(BIT_WIDTH-1){1'b0}}};
            pack_unf = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid;
            result    <= pack_res;
            overflow  <= pack_ovf;
            underflow <= pack_unf;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fpmul_bf16_pipe.sv
// tb_fpmul_bf16_pipe: directed self-checking bench for fpmul_bf16_pipe.
`default_nettype none

module tb_fpmul_bf16_pipe;

`ifdef FPMUL_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_operand, b_operand;
    logic        in_valid, in_ready;
    logic [15:0] result;
    logic        overflow, underflow, out_valid, out_ready;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fpmul_bf16_pipe #(.BIT_WIDTH(16), .EXP_BIAS(127)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_operand (a_operand),
        .b_operand (b_operand),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        ov;
        logic        un;
    } vec_t;

    // Present one pair for a single cycle; return the first valid output and its latency.
    task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] r, output logic ov, output logic un,
                           output int lat);
        @(negedge clk);
        a_operand = a;
        b_operand = b;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        r  = result;
        ov = overflow;
        un = underflow;
    endtask

    task automatic test_reset;
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_operand = 16'h0000;
        b_operand = 16'h0000;
        #12;
        vectors++;
        if ({out_valid, overflow, underflow, in_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_ctrl: got {ov,of,uf,ir}=%b expected 0001",
                     {out_valid, overflow, underflow, in_ready});
        end
        vectors++;
        if (result !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_result: got %h expected 0000", result);
        end
        // Pair presented together with reset release: accepted on the first rising edge.
        @(negedge clk);
        rst       = 1'b0;
        a_operand = 16'h3F80;
        b_operand = 16'h4000;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (result !== 16'h4000 || lat != 3) begin
            miscompares++;
            $display("FAIL first_after_reset: got %h lat %0d expected 4000 lat 3", result, lat);
        end
    endtask

    task automatic test_basic;
        logic [15:0] r;
        logic ov, un;
        int lat;
        run_one(16'h3F80, 16'h3F80, r, ov, un, lat);
        vectors++;
        if (r !== 16'h3F80 || {ov, un} !== 2'b00) begin
            miscompares++;
            $display("FAIL one_x_one: got %h flags %b expected 3f80 flags 00", r, {ov, un});
        end
        vectors++;
        if (lat != 3) begin
            miscompares++;
            $display("FAIL latency: got %0d expected 3", lat);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pulse: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_vectors;
        vec_t v[$];
        logic [15:0] r;
        logic ov, un;
        int lat;
        v.push_back('{16'h4000, 16'h4040, 16'h40C0, 1'b0, 1'b0});
        v.push_back('{16'hBF80, 16'h4000, 16'hC000, 1'b0, 1'b0});
        v.push_back('{16'h4040, 16'h4040, 16'h4110, 1'b0, 1'b0});
        v.push_back('{16'h7F00, 16'h7F00, 16'h7F80, 1'b1, 1'b0});
        v.push_back('{16'hFF00, 16'h7F00, 16'hFF80, 1'b1, 1'b0});
        v.push_back('{16'h7F00, 16'h4000, 16'h7F80, 1'b1, 1'b0});
        v.push_back('{16'h7F00, 16'h3F80, 16'h7F00, 1'b0, 1'b0});
        v.push_back('{16'h0080, 16'h0080, 16'h0000, 1'b0, 1'b1});
        v.push_back('{16'h0080, 16'h3F00, 16'h0000, 1'b0, 1'b1});
        v.push_back('{16'h0080, 16'h3F80, 16'h0080, 1'b0, 1'b0});
        v.push_back('{16'h7F80, 16'h0000, 16'h7FC0, 1'b0, 1'b0});
        v.push_back('{16'h0000, 16'h7F80, 16'h7FC0, 1'b0, 1'b0});
        v.push_back('{16'hFF80, 16'h3F80, 16'hFF80, 1'b0, 1'b0});
        v.push_back('{16'h7F80, 16'hC000, 16'hFF80, 1'b0, 1'b0});
        v.push_back('{16'h7F80, 16'h7F80, 16'h7F80, 1'b0, 1'b0});
        v.push_back('{16'h7FC1, 16'h3F80, 16'h7FC0, 1'b0, 1'b0});
        v.push_back('{16'h7F80, 16'hFFC0, 16'h7FC0, 1'b0, 1'b0});
        v.push_back('{16'h8000, 16'h4000, 16'h8000, 1'b0, 1'b0});
        v.push_back('{16'h0001, 16'h4000, 16'h0000, 1'b0, 1'b0});
        v.push_back('{16'h3FC0, 16'h3FC1, RNE ? 16'h4011 : 16'h4010, 1'b0, 1'b0});
        v.push_back('{16'h3F81, 16'h3FC0, RNE ? 16'h3FC2 : 16'h3FC1, 1'b0, 1'b0});
        v.push_back('{16'h3F83, 16'h3FC0, 16'h3FC4, 1'b0, 1'b0});
        v.push_back('{16'h7F35, 16'h3FB5, RNE ? 16'h7F80 : 16'h7F7F, RNE, 1'b0});
        foreach (v[i]) begin
            run_one(v[i].a, v[i].b, r, ov, un, lat);
            vectors++;
            if (r !== v[i].r || {ov, un} !== {v[i].ov, v[i].un} || lat != 3) begin
                miscompares++;
                $display("FAIL vec%0d %h*%h: got %h flags %b lat %0d expected %h flags %b lat 3",
                         i, v[i].a, v[i].b, r, {ov, un}, lat, v[i].r, {v[i].ov, v[i].un});
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] pa [4] = '{16'h3F80, 16'h4000, 16'hBF80, 16'h4040};
        logic [15:0] pb [4] = '{16'h4000, 16'h4040, 16'h4000, 16'h4040};
        logic [15:0] ex [4] = '{16'h4000, 16'h40C0, 16'hC000, 16'h4110};
        logic [15:0] got[$];
        int  sent  = 0;
        int  stall = 0;
        bit  first = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (sent < 4) begin
                in_valid  = 1'b1;
                a_operand = pa[sent];
                b_operand = pb[sent];
            end else begin
                in_valid = 1'b0;
            end
            if (first && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (!out_ready) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_in_ready: cycle %0d got %b expected 0", stall, in_ready);
                end
                vectors++;
                if (got.size() >= 4 || out_valid !== 1'b1 || result !== ex[got.size() % 4]) begin
                    miscompares++;
                    $display("FAIL stall_hold: cycle %0d got %h valid %b expected %h valid 1",
                             stall, result, out_valid, ex[got.size() % 4]);
                end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                got.push_back(result);
                first = 1'b1;
            end
        end
        out_ready = 1'b1;
        vectors++;
        if (got.size() != 4) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d results expected 4", got.size());
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== ex[i]) begin
                miscompares++;
                $display("FAIL b2b_order%0d: got %h expected %h", i,
                         (i < got.size()) ? got[i] : 16'hxxxx, ex[i]);
            end
        end
    endtask

    task automatic test_reset_inflight;
        logic [15:0] r;
        logic ov, un;
        int lat;
        int seen;
        @(negedge clk);
        out_ready = 1'b0;
        a_operand = 16'h7F00;
        b_operand = 16'h7F00;
        in_valid  = 1'b1;
        @(negedge clk);
        a_operand = 16'h3F80;
        b_operand = 16'h3F80;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (out_valid !== 1'b1 || result !== 16'h7F80 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL inflight_pre: got %h valid %b ovf %b expected 7f80 valid 1 ovf 1",
                     result, out_valid, overflow);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, overflow, underflow, in_ready} !== 4'b0001 || result !== 16'h0000) begin
            miscompares++;
            $display("FAIL inflight_reset: got {ov,of,uf,ir}=%b result %h expected 0001 result 0000",
                     {out_valid, overflow, underflow, in_ready}, result);
        end
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL stale_after_reset: got %0d valid cycles expected 0", seen);
        end
        run_one(16'h4000, 16'h4040, r, ov, un, lat);
        vectors++;
        if (r !== 16'h40C0 || {ov, un} !== 2'b00 || lat != 3) begin
            miscompares++;
            $display("FAIL post_reset_pair: got %h flags %b lat %0d expected 40c0 flags 00 lat 3",
                     r, {ov, un}, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_back_to_back();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
